// File: rtl/led_pwm_pkg.sv
// Shared types for the multi-channel LED PWM driver.
package led_pwm_pkg;

   typedef enum logic [2:0] {
      MODE_OFF     = 3'd0,
      MODE_ON      = 3'd1,
      MODE_BLINK   = 3'd2,
      MODE_PWM     = 3'd3,
      MODE_BREATHE = 3'd4
   } led_mode_t;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: shadow/active config, optional breathe engine and registered compare.
// Breathe logic is built only when LED_PWM_BREATHE_EN is defined; otherwise mode 4 acts as PWM.
module led_pwm_chan
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS     = 8,
   parameter int BREATHE_STEP = 2
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                wr,
   input  logic [2:0]          wr_mode,
   input  logic [PWM_BITS-1:0] wr_duty,
   input  logic                load,
   input  logic                blink_dark,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led
);

   logic [2:0]          shd_mode_q, act_mode_q, nxt_mode;
   logic [PWM_BITS-1:0] shd_duty_q, act_duty_q, nxt_duty, eff;
   logic                force_on, led_q;

   // A write landing on the boundary cycle bypasses the shadow so it takes effect immediately.
   assign nxt_mode = wr ? wr_mode : shd_mode_q;
   assign nxt_duty = wr ? wr_duty : shd_duty_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         shd_mode_q <= MODE_OFF;
         shd_duty_q <= '0;
         act_mode_q <= MODE_OFF;
         act_duty_q <= '0;
      end else begin
         if (wr) begin
            shd_mode_q <= wr_mode;
            shd_duty_q <= wr_duty;
         end
         if (load) begin
            act_mode_q <= nxt_mode;
            act_duty_q <= nxt_duty;
         end
      end
   end

`ifdef LED_PWM_BREATHE_EN
   localparam int SW = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
   localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] level_q;
   logic                dir_down_q;
   logic [SW-1:0]       step_q;
   logic                restart;

   assign restart = (nxt_mode == MODE_BREATHE) &&
                    ((act_mode_q != MODE_BREATHE) || (nxt_duty != act_duty_q));

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         level_q    <= '0;
         dir_down_q <= 1'b0;
         step_q     <= '0;
      end else if (load) begin
         if (restart) begin
            level_q    <= '0;
            dir_down_q <= 1'b0;
            step_q     <= '0;
         end else if ((act_mode_q == MODE_BREATHE) && (act_duty_q != '0)) begin
            if (step_q != SW'(BREATHE_STEP - 1)) begin
               step_q <= step_q + SW'(1);
            end else begin
               step_q <= '0;
               // Reverse on the step that reaches a bound so the peak/floor lasts one step only.
               if (!dir_down_q) begin
                  level_q <= level_q + LVL_ONE;
                  if (level_q + LVL_ONE == act_duty_q) dir_down_q <= 1'b1;
               end else begin
                  level_q <= level_q - LVL_ONE;
                  if (level_q == LVL_ONE) dir_down_q <= 1'b0;
               end
            end
         end
      end
   end
`endif

   always_comb begin
      force_on = 1'b0;
      eff      = '0;
      case (act_mode_q)
         MODE_ON:      force_on = 1'b1;
         MODE_PWM:     eff = act_duty_q;
         MODE_BLINK:   eff = blink_dark ? '0 : act_duty_q;
`ifdef LED_PWM_BREATHE_EN
         MODE_BREATHE: eff = level_q;
`else
         MODE_BREATHE: eff = act_duty_q;
`endif
         default:      eff = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         led_q <= 1'b0;
      end else begin
         led_q <= force_on | (pwm_cnt < eff);
      end
   end

   assign led = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver top: prescaler, shared PWM/blink counters and period_start.
// Define LED_PWM_BREATHE_EN to build the per-channel breathe engines.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int NR_CHAN      = 3,
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE     = 98,
   parameter int BLINK_SHIFT  = 6,
   parameter int BREATHE_STEP = 2,
   localparam int CW          = (NR_CHAN > 1) ? $clog2(NR_CHAN) : 1
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                cfg_valid,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [2:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [NR_CHAN-1:0]  led_out,
   output logic                period_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = BLINK_SHIFT + 1;

   logic [PW-1:0]       presc_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [BW-1:0]       blink_cnt_q;
   logic                period_start_q;
   logic                tick, wrap;

   assign tick = (presc_q == PW'(PRESCALE - 1));
   assign wrap = tick && (pwm_cnt_q == '1);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         presc_q        <= '0;
         pwm_cnt_q      <= '0;
         blink_cnt_q    <= '0;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= tick ? '0 : presc_q + PW'(1);
         period_start_q <= wrap;
         if (tick) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
         if (wrap) blink_cnt_q <= blink_cnt_q + BW'(1);
      end
   end

   for (genvar i = 0; i < NR_CHAN; i++) begin : g_chan
      led_pwm_chan #(
         .PWM_BITS     (PWM_BITS),
         .BREATHE_STEP (BREATHE_STEP)
      ) u_chan (
         .clk        (clk),
         .reset_     (reset_),
         .wr         (cfg_valid && (cfg_chan == CW'(i))),
         .wr_mode    (cfg_mode),
         .wr_duty    (cfg_duty),
         .load       (wrap),
         .blink_dark (blink_cnt_q[BLINK_SHIFT]),
         .pwm_cnt    (pwm_cnt_q),
         .led        (led_out[i])
      );
   end

   assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with PRESCALE=2, PWM_BITS=4 (32-cycle period).
module tb_led_pwm_ctrl;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_chan = '0;
   logic [2:0] cfg_mode = '0;
   logic [3:0] cfg_duty = '0;
   logic [2:0] led_out;
   logic       period_start;

   int checks = 0;
   int errors = 0;
   int ps_cnt = 0;

   led_pwm_ctrl #(
      .NR_CHAN      (3),
      .PWM_BITS     (4),
      .PRESCALE     (2),
      .BLINK_SHIFT  (1),
      .BREATHE_STEP (1)
   ) dut (
      .clk          (clk),
      .reset_       (reset_),
      .cfg_valid    (cfg_valid),
      .cfg_chan     (cfg_chan),
      .cfg_mode     (cfg_mode),
      .cfg_duty     (cfg_duty),
      .led_out      (led_out),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   // Number of periods completed since reset; blink phase in a period is (ps_cnt+1) mod 4.
   always @(posedge clk) if (period_start) ps_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic write_cfg(input int ch, input int mode, input int duty);
      cfg_chan  = 2'(ch);
      cfg_mode  = 3'(mode);
      cfg_duty  = 4'(duty);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Advance to the next period_start, counting high samples of led_out[ch] on the way.
   task automatic wait_ps(input int ch, output int ones);
      bit found = 1'b0;
      ones = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         ones += int'(led_out[ch]);
         if (period_start) found = 1'b1;
      end
      if (!found) check("ps_timeout", 32'd0, 32'd1);
   endtask

   // Starting on a period_start sample, record led_out[ch] for one full period.
   // With wr_last set, a write to ch is presented on the wrap cycle of that period.
   task automatic measure(input int ch, input bit wr_last, input int wmode, input int wduty,
                          output logic [31:0] pat);
      pat = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         cfg_valid = 1'b0;
         pat[i] = led_out[ch];
         if (wr_last && i == 30) begin
            cfg_chan  = 2'(ch);
            cfg_mode  = 3'(wmode);
            cfg_duty  = 4'(wduty);
            cfg_valid = 1'b1;
         end
      end
      check("period_align", 32'(period_start), 32'd1);
   endtask

   logic [31:0] breathe_exp [8];
   logic [31:0] pat;
   int          ones;
   int          n;
   bit          lit;

   initial begin
`ifdef LED_PWM_BREATHE_EN
      breathe_exp = '{32'h0, 32'h3, 32'hF, 32'h3F, 32'hF, 32'h3, 32'h0, 32'h3};
`else
      breathe_exp = '{default: 32'h3F};
`endif
      // Reset held with config writes active.
      cfg_chan  = 2'd0;
      cfg_mode  = 3'd1;
      cfg_duty  = 4'd15;
      cfg_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_ps", 32'(period_start), 32'd0);
      cfg_valid = 1'b0;
      reset_    = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (period_start) break;
      end
      check("first_ps", 32'(n), 32'd32);
      measure(0, 1'b0, 0, 0, pat);
      check("rst_cfg_ignored", pat, 32'h0);

      // PWM duty 5 written mid-period.
      write_cfg(0, 3, 5);
      wait_ps(0, ones);
      check("pwm5_before", 32'(ones), 32'd0);
      measure(0, 1'b0, 0, 0, pat);
      check("pwm5_pat", pat, 32'h0000_03FF);
      measure(0, 1'b0, 0, 0, pat);
      check("pwm5_pat2", pat, 32'h0000_03FF);

      write_cfg(0, 3, 0);
      wait_ps(0, ones);
      measure(0, 1'b0, 0, 0, pat);
      check("pwm0", pat, 32'h0);

      write_cfg(0, 3, 15);
      wait_ps(0, ones);
      measure(0, 1'b0, 0, 0, pat);
      check("pwm15", pat, 32'h3FFF_FFFF);

      // ON, invalid channel, unused mode.
      write_cfg(1, 1, 0);
      wait_ps(1, ones);
      check("on_before", 32'(ones), 32'd0);
      measure(1, 1'b0, 0, 0, pat);
      check("on", pat, 32'hFFFF_FFFF);

      write_cfg(3, 3, 8);
      wait_ps(2, ones);
      measure(0, 1'b0, 0, 0, pat);
      check("inval_ch0", pat, 32'h3FFF_FFFF);
      measure(1, 1'b0, 0, 0, pat);
      check("inval_ch1", pat, 32'hFFFF_FFFF);
      measure(2, 1'b0, 0, 0, pat);
      check("inval_ch2", pat, 32'h0);

      write_cfg(1, 6, 15);
      wait_ps(1, ones);
      measure(1, 1'b0, 0, 0, pat);
      check("mode6_off", pat, 32'h0);

      // Write on the wrap cycle, then two writes in one period.
      measure(2, 1'b1, 3, 8, pat);
      check("coll_before", pat, 32'h0);
      measure(2, 1'b0, 0, 0, pat);
      check("coll_applied", pat, 32'h0000_FFFF);

      write_cfg(2, 3, 3);
      write_cfg(2, 3, 12);
      wait_ps(2, ones);
      measure(2, 1'b0, 0, 0, pat);
      check("last_wins", pat, 32'h00FF_FFFF);

      // Blink: two lit periods of duty 15, two dark.
      write_cfg(0, 2, 15);
      wait_ps(0, ones);
      for (int p = 0; p < 4; p++) begin
         lit = ((ps_cnt + 1) % 4) < 2;
         measure(0, 1'b0, 0, 0, pat);
         check($sformatf("blink_p%0d", p), pat, lit ? 32'h3FFF_FFFF : 32'h0);
      end

      // Breathe peak 3 (constant duty 3 when the breathe engine is not built).
      write_cfg(2, 4, 3);
      wait_ps(2, ones);
      for (int p = 0; p < 8; p++) begin
         measure(2, 1'b0, 0, 0, pat);
         check($sformatf("breathe_p%0d", p), pat, breathe_exp[p]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Parametrised multi-channel LED driver that replaces the bare free-running-counter LED blink on the board top level. It derives a PWM timebase from the 25 MHz board oscillator and drives NR_CHAN LED pads, each independently set to off, on, blink, PWM or breathe through a small write-only config port. Config writes are shadowed and applied only at PWM period boundaries, so LED outputs never glitch. It sits between the board-level control logic and the led_*_pad_out pins.

## Interface
- NR_CHAN, 3: number of LED channels (1..16).
- PWM_BITS, 8: PWM counter and duty width.
- PRESCALE, 98: osc cycles per PWM step (≥1); period = PRESCALE·2^PWM_BITS cycles.
- BLINK_SHIFT, 6: blink half-period = 2^BLINK_SHIFT PWM periods.
- BREATHE_STEP, 2: PWM periods per breathe duty step.

- clk  in  1  board oscillator (osc25_pad_in at top level)
- reset_  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write strobe, one cycle, always accepted
- cfg_chan  in  CW = max(1, $clog2(NR_CHAN))  target channel
- cfg_mode  in  3  OFF=0, ON=1, BLINK=2, PWM=3, BREATHE=4
- cfg_duty  in  PWM_BITS  duty for PWM/BLINK; peak duty for BREATHE
- led_out  out  NR_CHAN  registered LED drive, active-high
- period_start  out  1  one-cycle pulse at each PWM period boundary

## Operation
- Prescaler counts 0..PRESCALE-1. tick is asserted on the cycle where it equals PRESCALE-1.
- pwm_cnt (PWM_BITS) increments on tick and wraps from all-ones to 0. The wrap tick asserts period_start on the next cycle, registered.
- Per channel: shadow {mode, duty} written on cfg_valid; active {mode, duty} loaded from shadow at period boundary.
- A write coinciding with a boundary is applied at that boundary.
- A write with cfg_chan ≥ NR_CHAN is ignored. Modes 5..7 behave as OFF.
- A later write to the same channel before a boundary overwrites the earlier one; only the last write applies.
- Effective duty eff:
  - OFF: 0.
  - ON: led forced 1, compare bypassed.
  - PWM: duty.
  - BLINK: duty while blink_cnt[BLINK_SHIFT] = 0, else 0.
  - BREATHE: level.
- blink_cnt is a shared (BLINK_SHIFT+1)-bit counter, incremented per period, wrapping.
- led_out[i] = (pwm_cnt < eff). duty 0 gives constant 0; duty all-ones gives on for 2^PWM_BITS−1 of 2^PWM_BITS steps.
- Breathe engine per channel:
  - level ramps +1 every BREATHE_STEP periods up to duty, then −1 down to 0, then repeats.
  - Direction reverses on the step that reaches the bound; the bound is not held for an extra step.
  - Entering BREATHE, or changing duty while in BREATHE, restarts at level=0, direction up.
  - duty=0 in BREATHE holds level 0.
- Reset (async assert, synchronous deassert handled at top level):
  - prescaler, pwm_cnt, blink_cnt, step counters, levels: 0.
  - All shadow/active modes OFF, duties 0, led_out=0, period_start=0.
- Reset mid-period aborts immediately; the first period after release starts from pwm_cnt=0.

## Timing
- led_out latency: 1 clk after the pwm_cnt value it reflects. Mode/duty change is visible on led_out on the first cycle of the new period.
- Config-to-effect latency ≤ PRESCALE·2^PWM_BITS + 1 cycles.
- All outputs are registered; no combinational path from cfg_* to led_out.
- Arithmetic is unsigned. The compare is PWM_BITS wide. Counters wrap silently.

## Configuration
- LED_PWM_BREATHE_EN defined: BREATHE mode and per-channel level/direction/step logic are built.
- Undefined: no breathe logic is built, and cfg_mode=4 is treated as PWM using cfg_duty.

## Structure
- Package led_pwm_pkg: mode enum led_mode_t (3 bits) and constants MODE_OFF..MODE_BREATHE.
- Sub-module led_pwm_chan: one channel's shadow/active registers, breathe engine and output compare, instantiated NR_CHAN times.
- Top block holds the prescaler, pwm_cnt, blink_cnt and period_start.

## Test plan
All cases use PRESCALE=2, PWM_BITS=4, BLINK_SHIFT=1, BREATHE_STEP=1.
- Reset: hold reset_=0 with cfg writes active -> led_out=0 and period_start=0. After release, the first period_start occurs after 32 cycles.
- PWM duty: ch0 PWM duty=5, written mid-period -> unchanged until boundary, then high for exactly 10 of every 32 cycles. Duty 0 gives constant low. Duty 15 gives low for 2 cycles per period.
- ON/OFF/invalid: ch1 ON -> constant 1 from the next period. cfg_chan=3 -> no channel changes. Mode 6 -> channel is off.
- Boundary collision: write ch2 PWM duty=8 on the boundary cycle -> applied in that period. Two writes in one period -> only the last applies.
- Blink: ch0 BLINK duty=15 -> 2 periods of PWM-15, then 2 periods dark, repeating.
- Breathe (macro on): duty=3 -> per-period levels 0,1,2,3,2,1,0,1…. With the macro off, the same write gives constant PWM duty=3.
